// File: rtl/msrv32_trap_sequencer.sv
// Purpose : machine-mode trap/return sequencer driving the CSR trap strobes,
//           fetch PC-select and pipeline flush.
// Latency : Moore strobes, so a trap is taken 1 cycle after its request is sampled.
// Backpressure: none; sources hold their level into S_OPERATING to be taken.
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   exception inputs  : misaligned_instr_in, illegal_instr_in, ebreak_in,
//                       misaligned_load_in, misaligned_store_in, ecall_in
//   mret_in           : MRET decoded
//   interrupt inputs  : mie_in, meie/mtie/msie_in, meip/mtip/msip_in
//   CSR strobes       : set_epc_out, set_cause_out, cause_out[3:0], i_or_e_out,
//                       misaligned_exception_out, mie_clear_out, mie_set_out,
//                       instret_inc_out
//   fetch control     : pc_src_out[1:0], flush_out
module msrv32_trap_sequencer #(
    parameter int BOOT_HOLD = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       misaligned_instr_in,
    input  logic       illegal_instr_in,
    input  logic       ebreak_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       misaligned_exception_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out
);

    typedef enum logic [1:0] {
        S_RESET       = 2'b00,
        S_OPERATING   = 2'b01,
        S_TRAP_TAKEN  = 2'b10,
        S_TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_NEXT = 2'b01;
    localparam logic [1:0] PC_EPC  = 2'b10;
    localparam logic [1:0] PC_TRAP = 2'b11;

    localparam logic [3:0] CAUSE_MIS_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
    localparam logic [3:0] CAUSE_MIS_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MIS_STORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL     = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_SW    = 4'd3;
    localparam logic [3:0] CAUSE_IRQ_TMR   = 4'd7;

    localparam int CNT_W = (BOOT_HOLD < 2) ? 1 : $clog2(BOOT_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [3:0]       cause_q, cause_d;
    logic             i_or_e_q, i_or_e_d;
    logic             misaligned_q, misaligned_d;

    logic       exc;
    logic       irq;
    logic       irq_ext, irq_sw, irq_tmr;
    logic [3:0] exc_cause;
    logic       exc_misaligned;
    logic [3:0] irq_cause;

    // Request decode
    assign exc = misaligned_instr_in | illegal_instr_in | ebreak_in |
                 misaligned_load_in | misaligned_store_in | ecall_in;

    assign irq_ext = meie_in & meip_in;
    assign irq_sw  = msie_in & msip_in;
    assign irq_tmr = mtie_in & mtip_in;
    assign irq     = mie_in & (irq_ext | irq_sw | irq_tmr);

    // Exception cause priority encoder; only the misaligned class sets mtval from iadder.
    always_comb begin
        exc_cause      = CAUSE_ECALL;
        exc_misaligned = 1'b0;
        if (misaligned_instr_in) begin
            exc_cause      = CAUSE_MIS_INSTR;
            exc_misaligned = 1'b1;
        end else if (illegal_instr_in) begin
            exc_cause = CAUSE_ILLEGAL;
        end else if (ebreak_in) begin
            exc_cause = CAUSE_EBREAK;
        end else if (misaligned_load_in) begin
            exc_cause      = CAUSE_MIS_LOAD;
            exc_misaligned = 1'b1;
        end else if (misaligned_store_in) begin
            exc_cause      = CAUSE_MIS_STORE;
            exc_misaligned = 1'b1;
        end
    end

    // Interrupt cause priority: external, software, timer.
    always_comb begin
        irq_cause = CAUSE_IRQ_TMR;
        if (irq_ext) begin
            irq_cause = CAUSE_IRQ_EXT;
        end else if (irq_sw) begin
            irq_cause = CAUSE_IRQ_SW;
        end
    end

    // State and trap-info registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_RESET;
            boot_cnt_q   <= '0;
            cause_q      <= 4'd0;
            i_or_e_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            cause_q      <= cause_d;
            i_or_e_q     <= i_or_e_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state and trap-info capture
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        cause_d      = cause_q;
        i_or_e_d     = i_or_e_q;
        misaligned_d = misaligned_q;

        unique case (state_q)
            S_RESET: begin
                if (boot_cnt_q == CNT_LAST) begin
                    state_d = S_OPERATING;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            S_OPERATING: begin
                if (exc) begin
                    state_d      = S_TRAP_TAKEN;
                    cause_d      = exc_cause;
                    i_or_e_d     = 1'b0;
                    misaligned_d = exc_misaligned;
                end else if (irq) begin
                    state_d      = S_TRAP_TAKEN;
                    cause_d      = irq_cause;
                    i_or_e_d     = 1'b1;
                    misaligned_d = 1'b0;
                end else if (mret_in) begin
                    state_d = S_TRAP_RETURN;
                end
            end
            // Both trap states last one cycle; requests seen here are dropped.
            S_TRAP_TAKEN:  state_d = S_OPERATING;
            S_TRAP_RETURN: state_d = S_OPERATING;
            default:       state_d = S_RESET;
        endcase
    end

    // Moore outputs decoded from the state register. Because reset clears the
    // state asynchronously, the strobes vanish in the same cycle reset goes low.
    always_comb begin
        set_epc_out   = 1'b0;
        set_cause_out = 1'b0;
        mie_clear_out = 1'b0;
        mie_set_out   = 1'b0;
        pc_src_out    = PC_BOOT;
        flush_out     = 1'b1;

        unique case (state_q)
            S_RESET: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
            S_OPERATING: begin
                pc_src_out = PC_NEXT;
                flush_out  = 1'b0;
            end
            S_TRAP_TAKEN: begin
                set_epc_out   = 1'b1;
                set_cause_out = 1'b1;
                mie_clear_out = 1'b1;
                pc_src_out    = PC_TRAP;
                flush_out     = 1'b1;
            end
            S_TRAP_RETURN: begin
                mie_set_out = 1'b1;
                pc_src_out  = PC_EPC;
                flush_out   = 1'b1;
            end
            default: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
        endcase
    end

    // MRET itself retires; only an instruction being trapped does not.
    assign instret_inc_out = (state_q == S_OPERATING) & ~exc & ~irq;

    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign misaligned_exception_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_trap_sequencer.sv
// Purpose : directed self-checking bench for msrv32_trap_sequencer.
// Latency : checks taken #1 after each rising edge; trap state one edge after request.
// Backpressure: n/a.
module tb_msrv32_trap_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       misaligned_instr_in, illegal_instr_in, ebreak_in;
    logic       misaligned_load_in, misaligned_store_in, ecall_in, mret_in;
    logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
    logic       set_epc_out, set_cause_out, i_or_e_out, misaligned_exception_out;
    logic       mie_clear_out, mie_set_out, instret_inc_out, flush_out;
    logic [3:0] cause_out;
    logic [1:0] pc_src_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    msrv32_trap_sequencer #(.BOOT_HOLD(2)) dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .misaligned_instr_in      (misaligned_instr_in),
        .illegal_instr_in         (illegal_instr_in),
        .ebreak_in                (ebreak_in),
        .misaligned_load_in       (misaligned_load_in),
        .misaligned_store_in      (misaligned_store_in),
        .ecall_in                 (ecall_in),
        .mret_in                  (mret_in),
        .mie_in                   (mie_in),
        .meie_in                  (meie_in),
        .mtie_in                  (mtie_in),
        .msie_in                  (msie_in),
        .meip_in                  (meip_in),
        .mtip_in                  (mtip_in),
        .msip_in                  (msip_in),
        .set_epc_out              (set_epc_out),
        .set_cause_out            (set_cause_out),
        .cause_out                (cause_out),
        .i_or_e_out               (i_or_e_out),
        .misaligned_exception_out (misaligned_exception_out),
        .mie_clear_out            (mie_clear_out),
        .mie_set_out              (mie_set_out),
        .instret_inc_out          (instret_inc_out),
        .pc_src_out               (pc_src_out),
        .flush_out                (flush_out)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view of all single-bit strobes:
    // {set_epc, set_cause, mie_clear, mie_set, flush, instret_inc}
    function automatic logic [5:0] strobes();
        return {set_epc_out, set_cause_out, mie_clear_out, mie_set_out,
                flush_out, instret_inc_out};
    endfunction

    task automatic chk_str(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = strobes();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        misaligned_instr_in = 0; illegal_instr_in = 0; ebreak_in = 0;
        misaligned_load_in = 0; misaligned_store_in = 0; ecall_in = 0; mret_in = 0;
        mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0;
        meip_in = 0; mtip_in = 0; msip_in = 0;
    endtask

    initial begin
        clear_inputs();
        rst_in = 1'b0;
        #1;
        // Reset state
        chk("rst_pc", 4'(pc_src_out), 4'h0);
        chk_str("rst_str", 6'b000010);
        chk("rst_cause", cause_out, 4'h0);
        chk("rst_ie_mis", {2'b00, i_or_e_out, misaligned_exception_out}, 4'h0);
        tick(); tick();
        rst_in = 1'b1;
        #1;
        chk("boot0_pc", 4'(pc_src_out), 4'h0);
        tick();
        chk("boot1_pc", 4'(pc_src_out), 4'h0);
        chk_str("boot1_str", 6'b000010);
        tick();
        chk("op_pc", 4'(pc_src_out), 4'h1);
        chk_str("op_str", 6'b000001);

        // Illegal + ecall together: illegal wins
        illegal_instr_in = 1; ecall_in = 1;
        #1;
        chk_str("exc_req_str", 6'b000000);
        tick();
        clear_inputs();
        chk("ill_pc", 4'(pc_src_out), 4'h3);
        chk_str("ill_str", 6'b111010);
        chk("ill_cause", cause_out, 4'd2);
        chk("ill_ie_mis", {2'b00, i_or_e_out, misaligned_exception_out}, 4'b0000);
        tick();
        chk("ill_back_pc", 4'(pc_src_out), 4'h1);
        chk("ill_hold_cause", cause_out, 4'd2);

        // External + timer interrupt: external wins
        mie_in = 1; mtie_in = 1; mtip_in = 1; meie_in = 1; meip_in = 1;
        tick();
        clear_inputs();
        chk("irq_pc", 4'(pc_src_out), 4'h3);
        chk("irq_cause", cause_out, 4'd11);
        chk("irq_ie_mis", {2'b00, i_or_e_out, misaligned_exception_out}, 4'b0010);
        tick();

        // Same pending bits with global enable off: no trap
        mtie_in = 1; mtip_in = 1; meie_in = 1; meip_in = 1;
        #1;
        chk_str("irq_masked_str", 6'b000001);
        tick();
        chk("irq_masked_pc", 4'(pc_src_out), 4'h1);
        clear_inputs();

        // Misaligned load beats an interrupt
        misaligned_load_in = 1; meip_in = 1; meie_in = 1; mie_in = 1;
        tick();
        clear_inputs();
        chk("ld_cause", cause_out, 4'd4);
        chk("ld_ie_mis", {2'b00, i_or_e_out, misaligned_exception_out}, 4'b0001);
        tick();

        // Misaligned store and fetch-misaligned cause codes
        misaligned_store_in = 1; ecall_in = 1;
        tick();
        clear_inputs();
        chk("st_cause", cause_out, 4'd6);
        chk("st_mis", {3'b000, misaligned_exception_out}, 4'b0001);
        tick();
        misaligned_instr_in = 1; illegal_instr_in = 1;
        tick();
        clear_inputs();
        chk("mi_cause", cause_out, 4'd0);
        chk("mi_mis", {3'b000, misaligned_exception_out}, 4'b0001);
        tick();
        ecall_in = 1;
        tick();
        clear_inputs();
        chk("ecall_cause", cause_out, 4'd11);
        chk("ecall_mis", {2'b00, i_or_e_out, misaligned_exception_out}, 4'b0000);
        tick();

        // MRET retires and returns
        mret_in = 1;
        #1;
        chk_str("mret_req_str", 6'b000001);
        tick();
        clear_inputs();
        chk("mret_pc", 4'(pc_src_out), 4'h2);
        chk_str("mret_str", 6'b000110);
        // Request during S_TRAP_RETURN is ignored
        ecall_in = 1;
        tick();
        chk("mret_back_pc", 4'(pc_src_out), 4'h1);
        chk("mret_ign_cause", cause_out, 4'd11);
        clear_inputs();

        // MRET with software interrupt: interrupt wins, no mie_set
        mret_in = 1; msip_in = 1; msie_in = 1; mie_in = 1;
        tick();
        clear_inputs();
        chk("sw_pc", 4'(pc_src_out), 4'h3);
        chk("sw_cause", cause_out, 4'd3);
        chk_str("sw_str", 6'b111010);
        chk("sw_ie", {3'b000, i_or_e_out}, 4'b0001);
        tick();

        // Reset during S_TRAP_TAKEN aborts the trap immediately
        ebreak_in = 1;
        tick();
        clear_inputs();
        chk("brk_cause", cause_out, 4'd3);
        chk_str("brk_str", 6'b111010);
        rst_in = 1'b0;
        #1;
        chk_str("abort_str", 6'b000010);
        chk("abort_pc", 4'(pc_src_out), 4'h0);
        chk("abort_cause", cause_out, 4'd0);
        tick();
        rst_in = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
